// File: rtl/pwm_pkg.sv
// Shared PWM constants and the ramp FSM state type, also used by the PWM
// generator to size its duty comparison.
package pwm_pkg;
  localparam int DEF_DUTY_W   = 4;
  localparam int DEF_DUTY_MAX = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;
endpackage

// File: rtl/pwm_step_timer.sv
// Counts PWM period_end pulses while enabled and fires step_tick on the
// period boundary that completes every STEP_DIV periods.
module pwm_step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic period_end,
  output logic step_tick
);
  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] cnt;

  assign step_tick = en && period_end && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && period_end) begin
      cnt <= step_tick ? 8'd0 : cnt + 8'd1;
    end
  end
endmodule

// File: rtl/pwm_ramp_controller.sv
// Duty-cycle sequencer: accepts host/button target requests and walks duty_out
// toward the target one step per STEP_DIV PWM periods, only on period_end.
module pwm_ramp_controller
  import pwm_pkg::*;
#(
  parameter int DUTY_W    = DEF_DUTY_W,
  parameter int DUTY_MAX  = DEF_DUTY_MAX,
  parameter int INIT_DUTY = 5,
  parameter int STEP_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DUTY_W-1:0] target,
  output logic              busy
);
  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(INIT_DUTY);

  // valid/ready: a request transfers on any clk edge where cmd_valid and
  // cmd_ready are both high; the host holds cmd_duty stable until then.
  ramp_state_t       state, state_next;
  logic [DUTY_W-1:0] duty_q, duty_next, target_q, target_next;
  logic              hs, step_tick, timer_clr;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RAMP);
  assign duty_out  = duty_q;
  assign target    = target_q;
  assign hs        = cmd_valid && cmd_ready;
  assign timer_clr = (state_next == IDLE);

  pwm_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (timer_clr),
    .en         (busy),
    .period_end (period_end),
    .step_tick  (step_tick)
  );

  always_comb begin
    target_next = target_q;
    duty_next   = duty_q;
    // Host wins over buttons; saturation is tested before the +/-1.
    if (hs) begin
      target_next = (cmd_duty > MAX_V) ? MAX_V : cmd_duty;
    end else if (inc_pulse && !dec_pulse) begin
      if (target_q < MAX_V) target_next = target_q + 1'b1;
    end else if (dec_pulse && !inc_pulse) begin
      if (target_q != '0) target_next = target_q - 1'b1;
    end
    if (state == RAMP && step_tick && duty_q != target_q) begin
      duty_next = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
    end
    // Ramping exactly while duty and target disagree keeps busy truthful.
    state_next = (duty_next != target_next) ? RAMP : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_q   <= INIT_V;
      target_q <= INIT_V;
    end else begin
      state    <= state_next;
      duty_q   <= duty_next;
      target_q <= target_next;
    end
  end
endmodule
